// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 single-wire reader.
package dht11_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    WAIT_ACK,
    ACK_LOW,
    ACK_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK,
    ERR
  } state_t;

  localparam int unsigned NUM_BITS  = 40;
  localparam int unsigned BIT_CNT_W = 6;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned PAD_W     = 4;
  localparam int unsigned WORD_W    = PAD_W + 2 * BYTE_W;

  typedef logic [NUM_BITS-1:0] frame_t;

  // Filter-facing word: {pad, humidity integer, temperature integer}.
  function automatic logic [WORD_W-1:0] pack_word(input logic [BYTE_W-1:0] hum_int,
                                                  input logic [BYTE_W-1:0] tmp_int);
    return {{PAD_W{1'b0}}, hum_int, tmp_int};
  endfunction

  function automatic logic checksum_ok(input frame_t f);
    logic [BYTE_W-1:0] sum;
    sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return sum == f[7:0];
  endfunction

endpackage

// File: rtl/dht11_reader_us_tick_gen.sv
// One-cycle strobe every CLK_FREQ_MHZ sys_clk cycles (1 us timing base).
module us_tick_gen #(
  parameter int unsigned CLK_FREQ_MHZ = 50
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic us_tick_o
);

  localparam int unsigned CW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_FREQ_MHZ - 1);

  logic [CW-1:0] cnt_q;

  assign us_tick_o = (cnt_q == LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/dht11_reader.sv
// DHT11 single-wire master: periodic start pulse, response/bit timing,
// checksum verification and publication of humidity/temperature.
module dht11_reader
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_FREQ_MHZ  = 50,
  parameter int unsigned PERIOD_MS     = 1000,
  parameter int unsigned START_LOW_US  = 20000,
  parameter int unsigned BIT_THRESH_US = 50,
  parameter int unsigned TIMEOUT_US    = 200
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  inout  wire               dht11,
  output logic [WORD_W-1:0] data_out,
  output logic [BYTE_W-1:0] hum_dec,
  output logic [BYTE_W-1:0] tmp_dec,
  output logic              data_valid,
  output logic              crc_err,
  output logic              timeout_err
);

  localparam int unsigned MS_W = (PERIOD_MS > 1) ? $clog2(PERIOD_MS) : 1;
  localparam logic [MS_W-1:0] MS_LAST   = MS_W'(PERIOD_MS - 1);
  localparam logic [15:0]     START_CNT = 16'(START_LOW_US);
  localparam logic [15:0]     THR_CNT   = 16'(BIT_THRESH_US);
  localparam logic [15:0]     TMO_CNT   = 16'(TIMEOUT_US);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(NUM_BITS - 1);

  logic us_tick;

  us_tick_gen #(
    .CLK_FREQ_MHZ(CLK_FREQ_MHZ)
  ) u_tick (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .us_tick_o(us_tick)
  );

  // Input synchronizer and edge detection
  logic [1:0] sync_q;
  logic       prev_q;
  logic       line_s, rise, fall;

  assign line_s = sync_q[1];
  assign rise   = ~prev_q & line_s;
  assign fall   = prev_q & ~line_s;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], dht11};
      prev_q <= line_s;
    end
  end

  // Period timer
  logic [9:0]      us_in_ms_q, us_in_ms_d;
  logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
  logic            start_req_q, start_req_d;
  logic            ms_tick;

  always_comb begin
    ms_tick     = us_tick && (us_in_ms_q == 10'd999);
    us_in_ms_d  = us_in_ms_q;
    ms_cnt_d    = ms_cnt_q;
    start_req_d = 1'b0;
    if (us_tick) begin
      us_in_ms_d = (us_in_ms_q == 10'd999) ? '0 : us_in_ms_q + 10'd1;
    end
    if (ms_tick) begin
      if (ms_cnt_q == MS_LAST) begin
        ms_cnt_d    = '0;
        start_req_d = 1'b1;
      end else begin
        ms_cnt_d = ms_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      us_in_ms_q  <= '0;
      ms_cnt_q    <= '0;
      start_req_q <= 1'b0;
    end else begin
      us_in_ms_q  <= us_in_ms_d;
      ms_cnt_q    <= ms_cnt_d;
      start_req_q <= start_req_d;
    end
  end

  // FSM and data path
  state_t               state_q;
  logic [15:0]          cnt_q;
  logic [15:0]          cnt_restart;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  frame_t               shift_q;
  logic                 drive_q;
  logic [WORD_W-1:0]    data_q;
  logic [BYTE_W-1:0]    hum_dec_q, tmp_dec_q;
  logic                 valid_q, crc_err_q, tmo_err_q;
  logic                 tmo;

  // A tick coinciding with a state change belongs to the new phase, so a
  // phase of N us always measures exactly N regardless of tick alignment.
  assign cnt_restart = {15'd0, us_tick};
  assign tmo         = (cnt_q > TMO_CNT);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      drive_q   <= 1'b0;
      data_q    <= '0;
      hum_dec_q <= '0;
      tmp_dec_q <= '0;
      valid_q   <= 1'b0;
      crc_err_q <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (us_tick && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 16'd1;
      end
      unique case (state_q)
        IDLE: begin
          if (start_req_q) begin
            state_q <= START;
            cnt_q   <= cnt_restart;
            drive_q <= 1'b1;
          end
        end
        START: begin
          if (cnt_q >= START_CNT) begin
            state_q <= WAIT_ACK;
            cnt_q   <= cnt_restart;
            drive_q <= 1'b0;
          end
        end
        WAIT_ACK: begin
          if (fall) begin
            state_q <= ACK_LOW;
            cnt_q   <= cnt_restart;
          end else if (tmo) begin
            state_q <= ERR;
            cnt_q   <= cnt_restart;
          end
        end
        ACK_LOW: begin
          if (rise) begin
            state_q <= ACK_HIGH;
            cnt_q   <= cnt_restart;
          end else if (tmo) begin
            state_q <= ERR;
            cnt_q   <= cnt_restart;
          end
        end
        ACK_HIGH: begin
          if (fall) begin
            state_q   <= BIT_LOW;
            cnt_q     <= cnt_restart;
            bit_cnt_q <= '0;
          end else if (tmo) begin
            state_q <= ERR;
            cnt_q   <= cnt_restart;
          end
        end
        BIT_LOW: begin
          if (rise) begin
            state_q <= BIT_HIGH;
            cnt_q   <= cnt_restart;
          end else if (tmo) begin
            state_q <= ERR;
            cnt_q   <= cnt_restart;
          end
        end
        BIT_HIGH: begin
          if (fall) begin
            shift_q <= {shift_q[NUM_BITS-2:0], (cnt_q > THR_CNT)};
            cnt_q   <= cnt_restart;
            if (bit_cnt_q == LAST_BIT) begin
              state_q <= CHECK;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              state_q   <= BIT_LOW;
            end
          end else if (tmo) begin
            state_q <= ERR;
            cnt_q   <= cnt_restart;
          end
        end
        CHECK: begin
          if (checksum_ok(shift_q)) begin
            data_q    <= pack_word(shift_q[39:32], shift_q[23:16]);
            hum_dec_q <= shift_q[31:24];
            tmp_dec_q <= shift_q[15:8];
            valid_q   <= 1'b1;
            crc_err_q <= 1'b0;
            tmo_err_q <= 1'b0;
          end else begin
            crc_err_q <= 1'b1;
          end
          state_q <= IDLE;
          cnt_q   <= cnt_restart;
        end
        ERR: begin
          tmo_err_q <= 1'b1;
          state_q   <= IDLE;
          cnt_q     <= cnt_restart;
        end
        default: begin
          state_q <= IDLE;
          drive_q <= 1'b0;
        end
      endcase
    end
  end

  assign dht11       = drive_q ? 1'b0 : 1'bz;
  assign data_out    = data_q;
  assign hum_dec     = hum_dec_q;
  assign tmp_dec     = tmp_dec_q;
  assign data_valid  = valid_q;
  assign crc_err     = crc_err_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_dht11_reader.sv
// Self-checking bench for dht11_reader with a behavioural DHT11 sensor model.
`timescale 1ns/1ps
module tb_dht11_reader;

  localparam int unsigned CLK_MHZ  = 2;
  localparam int unsigned PER_MS   = 5;
  localparam int unsigned START_US = 300;
  localparam int unsigned THR_US   = 50;
  localparam int unsigned TMO_US   = 200;
  localparam longint      P_CYC    = longint'(PER_MS) * 1000 * CLK_MHZ;

  localparam logic [39:0] F_GOOD = 40'h3C_00_19_05_5A;
  localparam logic [39:0] F_BAD  = 40'h3C_00_19_05_5B;
  localparam logic [39:0] F_THR  = 40'h41_00_17_02_5A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sens_drv = 1'b0;
  wire         dht11;
  logic [19:0] data_out;
  logic [7:0]  hum_dec, tmp_dec;
  logic        data_valid, crc_err, timeout_err;

  pullup (dht11);
  assign dht11 = sens_drv ? 1'b0 : 1'bz;

  dht11_reader #(
    .CLK_FREQ_MHZ (CLK_MHZ),
    .PERIOD_MS    (PER_MS),
    .START_LOW_US (START_US),
    .BIT_THRESH_US(THR_US),
    .TIMEOUT_US   (TMO_US)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .dht11      (dht11),
    .data_out   (data_out),
    .hum_dec    (hum_dec),
    .tmp_dec    (tmp_dec),
    .data_valid (data_valid),
    .crc_err    (crc_err),
    .timeout_err(timeout_err)
  );

  always #250 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic [19:0] d;
    logic [7:0]  hd;
    logic [7:0]  td;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   e;
  int     dv_cnt = 0;
  longint dv_cyc = 0;
  longint last_fall = 0;

  always @(negedge clk) begin
    if (rst_n && data_valid) begin
      dv_cnt++;
      dv_cyc = cyc;
      check_eq("dv_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("data_out", data_out, e.d);
        check_eq("hum_dec", hum_dec, e.hd);
        check_eq("tmp_dec", tmp_dec, e.td);
      end
    end
  end

  task automatic wait_us(input int n);
    repeat (n * CLK_MHZ) @(negedge clk);
  endtask

  task automatic wait_low(output longint t0);
    longint n = 0;
    while (dht11 !== 1'b0 && n < P_CYC + 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("start_seen", dht11 === 1'b0, 1);
    t0 = cyc;
  endtask

  task automatic wait_high(output int len);
    len = 0;
    while (dht11 === 1'b0 && len < 4 * START_US * CLK_MHZ) begin
      @(negedge clk);
      len++;
    end
    check_eq("start_len", (len >= 2 * START_US - 1) && (len <= 2 * START_US + 1), 1);
  endtask

  // Sensor: ack 80/80 us, bits 50 us low then 27/70 us high. With thr set,
  // the first byte uses 50/51 us highs to probe the decode threshold.
  task automatic send_frame(input logic [39:0] f, input int nb, input bit thr);
    int hi;
    wait_us(30);
    sens_drv = 1'b1;
    wait_us(80);
    sens_drv = 1'b0;
    wait_us(80);
    for (int i = 0; i < nb; i++) begin
      sens_drv = 1'b1;
      wait_us(50);
      sens_drv = 1'b0;
      if (thr && i < 8) hi = f[39-i] ? 51 : 50;
      else hi = f[39-i] ? 70 : 27;
      wait_us(hi);
    end
    if (nb == 40) begin
      sens_drv = 1'b1;
      last_fall = cyc;
      wait_us(50);
      sens_drv = 1'b0;
    end
  endtask

  task automatic run_good(input logic [39:0] f, input bit thr, input logic [19:0] d,
                          input logic [7:0] hd, input logic [7:0] td);
    int dv0;
    exp_t x;
    x.d = d;
    x.hd = hd;
    x.td = td;
    exp_q.push_back(x);
    dv0 = dv_cnt;
    send_frame(f, 40, thr);
    wait_us(20);
    check_eq("dv_count", dv_cnt - dv0, 1);
    check_eq("dv_latency", 32'(dv_cyc - last_fall), 4);
    check_eq("scoreboard_empty", exp_q.size(), 0);
    check_eq("good_crc_err", crc_err, 0);
    check_eq("good_timeout_err", timeout_err, 0);
  endtask

  longint t_start, t_prev, rst_cyc;
  int     len, dv0, n;

  initial begin
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rst_data_out", data_out, 0);
    check_eq("rst_decs", {hum_dec, tmp_dec}, 0);
    check_eq("rst_flags", {data_valid, crc_err, timeout_err}, 0);
    check_eq("rst_line", dht11, 1);
    rst_n = 1'b1;
    rst_cyc = cyc;

    // Good frame after the power-up period
    wait_low(t_start);
    check_eq("first_start_delay", (t_start - rst_cyc >= P_CYC - 4) && (t_start - rst_cyc <= P_CYC + 6), 1);
    wait_high(len);
    run_good(F_GOOD, 1'b0, 20'h03C19, 8'h00, 8'h05);

    // Bad checksum
    t_prev = t_start;
    wait_low(t_start);
    check_eq("period_crc", 32'(t_start - t_prev), 32'(P_CYC));
    wait_high(len);
    dv0 = dv_cnt;
    send_frame(F_BAD, 40, 1'b0);
    wait_us(20);
    check_eq("crc_err_set", crc_err, 1);
    check_eq("crc_no_timeout", timeout_err, 0);
    check_eq("crc_no_dv", dv_cnt - dv0, 0);
    check_eq("crc_hold_data", data_out, 20'h03C19);
    check_eq("crc_hold_tmp_dec", tmp_dec, 8'h05);

    // No acknowledge
    t_prev = t_start;
    wait_low(t_start);
    check_eq("period_noack", 32'(t_start - t_prev), 32'(P_CYC));
    wait_high(len);
    n = 0;
    while (timeout_err !== 1'b1 && n < (TMO_US + 50) * CLK_MHZ) begin
      @(negedge clk);
      n++;
    end
    check_eq("noack_timeout_time", (n >= 2 * TMO_US) && (n <= 2 * TMO_US + 12), 1);
    check_eq("noack_crc_sticky", crc_err, 1);
    check_eq("noack_hold_data", data_out, 20'h03C19);

    // Next attempt one period later; threshold-probing good frame clears errors
    t_prev = t_start;
    wait_low(t_start);
    check_eq("period_retry", 32'(t_start - t_prev), 32'(P_CYC));
    wait_high(len);
    run_good(F_THR, 1'b1, 20'h04117, 8'h00, 8'h02);

    // Sensor stops after bit 17
    t_prev = t_start;
    wait_low(t_start);
    check_eq("period_mid", 32'(t_start - t_prev), 32'(P_CYC));
    wait_high(len);
    dv0 = dv_cnt;
    send_frame(F_GOOD, 18, 1'b0);
    wait_us(TMO_US + 50);
    check_eq("mid_timeout_err", timeout_err, 1);
    check_eq("mid_crc_err", crc_err, 0);
    check_eq("mid_hold_data", data_out, 20'h04117);
    check_eq("mid_no_dv", dv_cnt - dv0, 0);
    check_eq("mid_line_released", dht11, 1);

    // Reset during START
    t_prev = t_start;
    wait_low(t_start);
    check_eq("period_after_mid", 32'(t_start - t_prev), 32'(P_CYC));
    wait_us(50);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_line", dht11, 1);
    check_eq("rst_mid_data", data_out, 0);
    check_eq("rst_mid_decs", {hum_dec, tmp_dec}, 0);
    check_eq("rst_mid_flags", {data_valid, crc_err, timeout_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rst_cyc = cyc;
    wait_low(t_start);
    check_eq("restart_delay", (t_start - rst_cyc >= P_CYC - 4) && (t_start - rst_cyc <= P_CYC + 6), 1);
    wait_high(len);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dht11_reader.md
Name: dht11_reader

Overview:
- Single-wire master for the DHT11 sensor.
- Periodically issues the start pulse, times the sensor's response and 40 data bits, and verifies the checksum.
- Publishes humidity and temperature as a packed 20-bit word, which feeds the downstream averaging filter's din.
- Sits between the FPGA pad and the filter/display path.

Parameters:
- CLK_FREQ_MHZ, 50: sys_clk frequency in MHz, used to derive a 1 us tick.
- PERIOD_MS, 1000: interval between read transactions in ms, measured start to start.
- START_LOW_US, 20000: duration the master drives the line low, in us. Must be ≥18000.
- BIT_THRESH_US, 50: high-phase length above which a bit decodes as 1.
- TIMEOUT_US, 200: maximum duration of any sensor-driven phase before abort.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- dht11  inout  1  open-drain data line; driven 0 or released (Z), external pull-up
- data_out  out  20  {4'h0, hum_int[7:0], tmp_int[7:0]}
- hum_dec  out  8  humidity fractional byte
- tmp_dec  out  8  temperature fractional byte
- data_valid  out  1  one-cycle pulse when data_out updates
- crc_err  out  1  sticky until next successful read
- timeout_err  out  1  sticky until next successful read

Behaviour:
- Reset (async, sys_rst_n low): FSM to IDLE; line released; all outputs 0; counters, shift register and period timer cleared. Reset mid-transaction aborts immediately with the line released.
- Input path: dht11 passes through a 2-flop synchronizer. All edge detection uses the synchronized value; falling edge = prev 1, cur 0.
- Timing base: us_tick pulses once per CLK_FREQ_MHZ cycles. The phase counter counts us_ticks, saturates at 16 bits, and clears on every state change.
- Period timer: free-running ms counter. On reaching PERIOD_MS it raises a start request and reloads. The first request comes PERIOD_MS after reset, which covers sensor power-up.
- FSM:
  - IDLE: line released. On start request -> START.
  - START: drive 0. Once count ≥ START_LOW_US -> release line, go to WAIT_ACK.
  - WAIT_ACK: sensor falling edge -> ACK_LOW; count > TIMEOUT_US -> ERR.
  - ACK_LOW: rising edge -> ACK_HIGH; timeout -> ERR.
  - ACK_HIGH: falling edge -> BIT_LOW, bit_cnt = 0; timeout -> ERR.
  - BIT_LOW: rising edge -> BIT_HIGH; timeout -> ERR.
  - BIT_HIGH: on falling edge, shift in (count > BIT_THRESH_US); MSB first, 40-bit shift register.
    - If bit_cnt = 39 -> CHECK; else bit_cnt++ and go to BIT_LOW.
    - Timeout -> ERR. The final bit is terminated by the sensor's 50 us low, so its falling edge is always present.
  - CHECK (1 cycle): bytes B4..B0 in arrival order.
    - If (B4+B3+B2+B1) mod 256 == B0: register hum_int=B4, hum_dec=B3, tmp_int=B2, tmp_dec=B1; pulse data_valid; clear both error flags.
    - Else set crc_err and leave data outputs unchanged. Either way -> IDLE.
  - ERR (1 cycle): set timeout_err, data unchanged, -> IDLE.
- Latency: data_valid asserts exactly 2 sys_clk cycles after the synchronized falling edge of bit 39 (edge detect, then CHECK).
- Data outputs hold their last good value across failed reads.
- A start request arriving while not in IDLE is dropped. The next attempt occurs one PERIOD_MS later, with no queuing.
- Counter equal to threshold decodes as 0 (strict greater-than).
- Line is driven only in START; released in every other state, including immediately on reset.

Decomposition:
- Package dht11_pkg holds:
  - the state enum (IDLE, START, WAIT_ACK, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, CHECK, ERR);
  - the bit count constant 40;
  - the packed-word layout constants.
- Sub-module us_tick_gen (param CLK_FREQ_MHZ) supplies the 1 us strobe; it is shared with other timing blocks.
- Top contains the synchronizer, period timer, FSM and data path.

Test Plan:
- Behavioural sensor model (ack 80/80 us; bits 50 us low, then 27 us high for 0 or 70 us high for 1) sends 0x3C,0x00,0x19,0x05,0x5A -> data_out=20'h03C19, hum_dec=0, tmp_dec=5, data_valid 1 cycle, both error flags 0.
- Same frame with checksum 0x5B -> crc_err=1, no data_valid, data_out holds previous 20'h03C19.
- Model never acknowledges -> timeout_err=1 about 200 us after release; next attempt one period later; a good frame afterwards clears timeout_err.
- Model stops mid-frame after bit 17 -> timeout_err=1, FSM back in IDLE, line released.
- Bit-threshold boundary: high phases of 50 us and 51 us -> decode as 0 and 1 respectively.
- Reset asserted during START -> line immediately Z, all outputs 0; first new start pulse occurs PERIOD_MS after reset release, lasting ≥18 ms.
